// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared state type and occupancy helper for elastic pipeline stages
package mips_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t;
  localparam int OCC_W = 2;
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
    return s == SKID ? OCC_W'(2) : s == FULL ? OCC_W'(1) : OCC_W'(0);
  endfunction
endpackage

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with two-entry skid, flush and bubble counter
module pipe_stage_elastic
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);
  pipe_state_t state;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic in_fire, out_fire;
  // handshake outputs come from registered state only, so ready never depends on out_ready
  assign out_valid = state != EMPTY;
  assign in_ready = state != SKID;
  assign occupancy = occ_of(state);
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      out_ctrl <= '0;
      out_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_ready && !out_valid && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (flush) begin
        state <= EMPTY;
        out_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA) begin
          out_data <= '0;
          skid_data <= '0;
        end
      end else begin
        case (state)
          EMPTY: if (in_fire) begin
            state <= FULL;
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end
          FULL: if (in_fire && out_fire) begin
            out_ctrl <= in_ctrl;
            out_data <= in_data;
          end else if (in_fire) begin
            state <= SKID;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
          SKID: if (out_fire) begin
            state <= FULL;
            out_ctrl <= skid_ctrl;
            out_data <= skid_data;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed and randomized checks of two stage instances against a queue model
module tb_pipe_stage_elastic;
  localparam int CW = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset, in_valid, out_ready, flush;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_a, out_ctrl_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [1:0] occ_a, occ_b;
  logic [2:0] cnt_a;
  logic [15:0] cnt_b;
  int checks = 0;
  int errors = 0;
  logic [CW+DW-1:0] q[$];
  logic [CW+DW-1:0] res_a, res_b;
  logic [2:0] m_cnt_a;
  logic [15:0] m_cnt_b;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .CNT_W(3)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready), .out_ctrl(out_ctrl_a),
    .out_data(out_data_a), .flush(flush), .occupancy(occ_a), .bubble_cnt(cnt_a));

  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_ctrl(in_ctrl),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready), .out_ctrl(out_ctrl_b),
    .out_data(out_data_b), .flush(flush), .occupancy(occ_b), .bubble_cnt(cnt_b));

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic r, input logic f, input logic rs);
    in_valid = v;
    in_ctrl = c;
    in_data = d;
    out_ready = r;
    flush = f;
    reset = rs;
  endtask

  // model: a queue of held beats plus the last head value each variant keeps visible when empty
  task automatic tick();
    bit ov, ir;
    @(posedge clk);
    ov = q.size() > 0;
    ir = q.size() < 2;
    if (reset) begin
      q.delete();
      res_a = '0;
      res_b = '0;
      m_cnt_a = '0;
      m_cnt_b = '0;
    end else begin
      if (out_ready && !ov) begin
        if (m_cnt_a != 3'd7) m_cnt_a++;
        if (m_cnt_b != 16'hFFFF) m_cnt_b++;
      end
      if (flush) begin
        q.delete();
        res_a = {CW'(0), res_a[DW-1:0]};
        res_b = '0;
      end else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back({in_ctrl, in_data});
        if (q.size() > 0) begin
          res_a = q[0];
          res_b = q[0];
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 4'hA, 32'h1234, 1, 0, 1);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid_a); end
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready_a); end
    checks++; if (out_ctrl_a !== 4'h0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl_a); end
    checks++; if (out_data_a !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data_a); end
    checks++; if (occ_a !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occ_a); end
    checks++; if (cnt_a !== 3'd0 || cnt_b !== 16'd0) begin errors++; $display("FAIL reset_bubble got %0d/%0d exp 0/0", cnt_a, cnt_b); end
  endtask

  task automatic test_streaming();
    logic [2:0] c0;
    drive(1, 4'h1, 32'd1, 0, 0, 0);
    tick();
    c0 = cnt_a;
    for (int i = 2; i <= 8; i++) begin
      drive(1, CW'(i), DW'(i), 1, 0, 0);
      tick();
      checks++; if (out_data_a !== DW'(i) || out_valid_a !== 1'b1) begin errors++; $display("FAIL stream_data beat %0d got %0d v%0b exp %0d v1", i, out_data_a, out_valid_a, i); end
      checks++; if (occ_a !== 2'd1 || in_ready_a !== 1'b1) begin errors++; $display("FAIL stream_occ beat %0d got %0d r%0b exp 1 r1", i, occ_a, in_ready_a); end
    end
    checks++; if (cnt_a !== c0) begin errors++; $display("FAIL stream_bubble got %0d exp %0d", cnt_a, c0); end
    drive(0, 0, 0, 1, 0, 0);
    tick();
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b exp 0", out_valid_a); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_d[6] = '{1, 1, 1, 2, 3, 4};
    logic [1:0] exp_o[6] = '{1, 2, 2, 1, 1, 1};
    logic [DW-1:0] offer[6] = '{1, 2, 3, 3, 3, 4};
    logic rdy[6] = '{1, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'h3, offer[i], rdy[i], 0, 0);
      tick();
      checks++; if (out_data_a !== exp_d[i] || occ_a !== exp_o[i]) begin errors++; $display("FAIL bp_step %0d got d%0d o%0d exp d%0d o%0d", i, out_data_a, occ_a, exp_d[i], exp_o[i]); end
      checks++; if (in_ready_a !== (exp_o[i] != 2'd2)) begin errors++; $display("FAIL bp_ready %0d got %0b exp %0b", i, in_ready_a, exp_o[i] != 2'd2); end
    end
    drive(0, 0, 0, 1, 0, 0);
    tick();
    checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0) begin errors++; $display("FAIL bp_drain got v%0b o%0d exp v0 o0", out_valid_a, occ_a); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush_skid();
    drive(1, 4'hF, 32'h11, 0, 0, 0);
    tick();
    drive(1, 4'hF, 32'h22, 0, 0, 0);
    tick();
    checks++; if (occ_a !== 2'd2 || out_ctrl_a !== 4'hF) begin errors++; $display("FAIL fl_fill got o%0d c%h exp o2 cF", occ_a, out_ctrl_a); end
    drive(1, 4'h7, 32'h33, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b0 || occ_a !== 2'd0 || in_ready_a !== 1'b1) begin errors++; $display("FAIL fl_state got v%0b o%0d r%0b exp v0 o0 r1", out_valid_a, occ_a, in_ready_a); end
    checks++; if (out_ctrl_a !== 4'h0 || out_ctrl_b !== 4'h0) begin errors++; $display("FAIL fl_ctrl got %h/%h exp 0/0", out_ctrl_a, out_ctrl_b); end
    checks++; if (out_data_a !== 32'h11 || out_data_b !== 32'h0) begin errors++; $display("FAIL fl_data got %h/%h exp 11/0", out_data_a, out_data_b); end
    tick();
    checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin errors++; $display("FAIL fl_dropped got %0b/%0b exp 0/0", out_valid_a, out_valid_b); end
  endtask

  task automatic test_clear_data();
    drive(1, 4'h5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    checks++; if (out_data_a !== 32'hDEADBEEF || out_data_b !== 32'hDEADBEEF) begin errors++; $display("FAIL cd_load got %h/%h exp deadbeef", out_data_a, out_data_b); end
    drive(0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL cd_keep got %h exp deadbeef", out_data_a); end
    checks++; if (out_data_b !== 32'h0) begin errors++; $display("FAIL cd_clear got %h exp 0", out_data_b); end
    checks++; if (out_ctrl_a !== 4'h0 || out_ctrl_b !== 4'h0) begin errors++; $display("FAIL cd_ctrl got %h/%h exp 0/0", out_ctrl_a, out_ctrl_b); end
  endtask

  task automatic test_bubble();
    drive(0, 0, 0, 0, 0, 1);
    tick();
    checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL bub_reset got %0d exp 0", cnt_a); end
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      tick();
      checks++; if (cnt_a !== 3'((i > 7) ? 7 : i)) begin errors++; $display("FAIL bub_count %0d got %0d exp %0d", i, cnt_a, (i > 7) ? 7 : i); end
    end
    checks++; if (cnt_b !== 16'd10) begin errors++; $display("FAIL bub_wide got %0d exp 10", cnt_b); end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    checks++; if (cnt_a !== 3'd7) begin errors++; $display("FAIL bub_flush got %0d exp 7", cnt_a); end
    drive(0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (cnt_a !== 3'd0 || cnt_b !== 16'd0) begin errors++; $display("FAIL bub_clear got %0d/%0d exp 0/0", cnt_a, cnt_b); end
  endtask

  task automatic test_reset_mid();
    drive(1, 4'h9, 32'hAAAA, 0, 0, 0);
    tick();
    drive(1, 4'h9, 32'hBBBB, 0, 0, 0);
    tick();
    checks++; if (occ_a !== 2'd2) begin errors++; $display("FAIL rm_fill got %0d exp 2", occ_a); end
    drive(1, 4'h9, 32'hCCCC, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || occ_a !== 2'd0) begin errors++; $display("FAIL rm_state got v%0b r%0b o%0d exp v0 r1 o0", out_valid_a, in_ready_a, occ_a); end
    checks++; if (out_ctrl_a !== 4'h0 || out_data_a !== 32'h0 || cnt_a !== 3'd0) begin errors++; $display("FAIL rm_regs got c%h d%h b%0d exp 0 0 0", out_ctrl_a, out_data_a, cnt_a); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, CW'($urandom), DW'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      tick();
      checks++; if (out_valid_a !== (q.size() > 0) || out_valid_b !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid %0d got %0b/%0b exp %0b", i, out_valid_a, out_valid_b, q.size() > 0); end
      checks++; if (in_ready_a !== (q.size() < 2) || in_ready_b !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready %0d got %0b/%0b exp %0b", i, in_ready_a, in_ready_b, q.size() < 2); end
      checks++; if (occ_a !== 2'(q.size()) || occ_b !== 2'(q.size())) begin errors++; $display("FAIL rnd_occ %0d got %0d/%0d exp %0d", i, occ_a, occ_b, q.size()); end
      checks++; if ({out_ctrl_a, out_data_a} !== res_a) begin errors++; $display("FAIL rnd_head_a %0d got %h exp %h", i, {out_ctrl_a, out_data_a}, res_a); end
      checks++; if ({out_ctrl_b, out_data_b} !== res_b) begin errors++; $display("FAIL rnd_head_b %0d got %h exp %h", i, {out_ctrl_b, out_data_b}, res_b); end
      checks++; if (cnt_a !== m_cnt_a || cnt_b !== m_cnt_b) begin errors++; $display("FAIL rnd_bubble %0d got %0d/%0d exp %0d/%0d", i, cnt_a, cnt_b, m_cnt_a, m_cnt_b); end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_clear_data();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
